// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding, busy-cycle counts and FSM states.
// The control decoder uses the same opcode constants.
package mult_div_unit_pkg;

    localparam logic [3:0] MDU_OP_NONE = 4'd0;
    localparam logic [3:0] MULT        = 4'd1;
    localparam logic [3:0] MULTU       = 4'd2;
    localparam logic [3:0] DIV         = 4'd3;
    localparam logic [3:0] DIVU        = 4'd4;
    localparam logic [3:0] MFHI        = 4'd5;
    localparam logic [3:0] MFLO        = 4'd6;
    localparam logic [3:0] MTHI        = 4'd7;
    localparam logic [3:0] MTLO        = 4'd8;

    localparam logic [3:0] MUL_CYCLES  = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational arithmetic for mult/multu/div/divu; produces the HI/LO pair to be committed later.
// Signed division works on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_zero
);

    logic [63:0] prod;
    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        prod     = '0;
        sgn      = (op == MULT) || (op == DIV);
        neg_a    = sgn & a[31];
        neg_b    = sgn & b[31];
        mag_a    = neg_a ? (~a + 32'd1) : a;
        mag_b    = neg_b ? (~b + 32'd1) : b;
        div_zero = is_div_op(op) && (b == '0);
        quo      = '0;
        rem      = '0;
        hi_next  = '0;
        lo_next  = '0;

        if (op == MULT || op == MULTU) begin
            prod = {{32{neg_a}}, a} * {{32{neg_b}}, b};
            hi_next = prod[63:32];
            lo_next = prod[31:0];
        end else if (is_div_op(op) && !div_zero) begin
            quo     = mag_a / mag_b;
            rem     = mag_a % mag_b;
            lo_next = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
            hi_next = neg_a ? (~rem + 32'd1) : rem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: results are computed at issue, held pending,
// and committed to HI/LO when the busy counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_Op_E,
    input  logic [31:0] SrcA_E,
    input  logic [31:0] SrcB_E,
    output logic        Start_E,
    output logic        Busy_E,
    output logic [31:0] MDU_Out_E,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_pend_q, hi_pend_d;
    logic [31:0] lo_pend_q, lo_pend_d;
    logic        busy_q;

    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic        div_zero;

    mdu_arith u_arith (
        .op       (MDU_Op_E),
        .a        (SrcA_E),
        .b        (SrcB_E),
        .hi_next  (hi_next),
        .lo_next  (lo_next),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_pend_q <= '0;
            lo_pend_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            busy_q    <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;

        case (state_q)
            IDLE: begin
                if (is_start_op(MDU_Op_E)) begin
                    // Divide by zero re-commits the current HI/LO, so the common commit path leaves them unchanged.
                    hi_pend_d = div_zero ? hi_q : hi_next;
                    lo_pend_d = div_zero ? lo_q : lo_next;
                    count_d   = is_div_op(MDU_Op_E) ? DIV_CYCLES : MUL_CYCLES;
                    state_d   = RUN;
                end else if (MDU_Op_E == MTHI) begin
                    hi_d = SrcA_E;
                end else if (MDU_Op_E == MTLO) begin
                    lo_d = SrcA_E;
                end
            end
            RUN: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    hi_d    = hi_pend_q;
                    lo_d    = lo_pend_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Start_E   = !reset && (state_q == IDLE) && is_start_op(MDU_Op_E);
        Busy_E    = busy_q;
        MDU_Out_E = '0;
        if (!reset) begin
            if (MDU_Op_E == MFHI) begin
                MDU_Out_E = hi_q;
            end else if (MDU_Op_E == MFLO) begin
                MDU_Out_E = lo_q;
            end
        end
        HI = hi_q;
        LO = lo_q;
    end

endmodule
